alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Sequences the calculator ALU for the keypad FSM: accepts one op (lhs, rhs, op code) per start pulse.
//  Add/sub/mult: routes operands to the sumador/restador/multiplicador instances and registers the selected result.
//  DIV: runs an internal iterative restoring divider.
//  Returns result, remainder and flags with a one-cycle done pulse; sits between the keypad FSM and the display path.
// PARAMETERS
//  BITS   15   operand/result width (unsigned magnitude)
// PORTS
//  clk        in   1     system clock, all state on rising edge
//  reset_in   in   1     asynchronous, active-high reset
//  start      in   1     request; sampled only when busy=0
//  op         in   2     0=SUMA 1=RESTA 2=MULT 3=DIV
//  lhs        in   BITS  left operand
//  rhs        in   BITS  right operand
//  busy       out  1     op in progress; start ignored
//  done       out  1     one-cycle pulse, outputs valid
//  result     out  BITS  quotient/sum/diff/product
//  remainder  out  BITS  DIV remainder, else 0
//  neg        out  1     RESTA with lhs<rhs
//  err        out  1     overflow / out of range / div-by-0 / DIV disabled
// BEHAVIOUR
//  Reset (async, any state): state=IDLE.
//   busy=0, done=0, result=0, remainder=0, neg=0, err=0, iteration counter=0.
//  Operand capture: lhs, rhs, op latched on the edge where start=1 and busy=0 (edge E0).
//   The caller may change inputs afterwards.
//  States:
//   IDLE: start -> EXEC (op 0..2, or DIV with rhs=0 / DIV disabled), or -> DIV_RUN (DIV, rhs!=0).
//         busy=1 from E0.
//   EXEC: one cycle; on E1 register outputs, done=1, busy=0, -> IDLE.
//   DIV_RUN: one restoring shift-subtract step per edge, E1..E_BITS, MSB first; counter 0..BITS-1.
//         On E_(BITS+1) register quotient/remainder, done=1, busy=0, -> IDLE.
//  Latency: add/sub/mult/errors have done high after E1.
//   DIV has done high after E_(BITS+1) (16 edges at BITS=15).
//  done is high exactly one cycle. Outputs hold until the next done; not cleared by start.
//  start while busy=1: ignored, not queued.
//   start on the same edge that done rises: ignored (busy still 1 at that edge).
//   start in the cycle done=1: accepted.
//  Arithmetic per op (unsigned BITS):
//   SUMA: result=lhs+rhs. err=carry out of BITS.
//   RESTA: result=|lhs-rhs|. neg=(lhs<rhs). err=0.
//   MULT: result=lhs*rhs. err=(product >= 2^BITS).
//   DIV: result=lhs/rhs, remainder=lhs%rhs. rhs=0 -> err=1.
//  On err=1: result=0, remainder=0, neg=0.
//  neg and remainder are 0 for ops that do not define them.
//  Reset mid-DIV_RUN: abort immediately, no done pulse.
// CONFIGURATION
//  ALU_SEQ_DIV_EN defined:
//   divider datapath, DIV_RUN state and counter compiled in. DIV behaves as above.
//  ALU_SEQ_DIV_EN undefined:
//   no divider logic, DIV_RUN unreachable.
//   op=3 takes the EXEC path: done after E1 with err=1, result=0, remainder=0.
// TESTING (BITS=15)
//  1. SUMA 12,30 -> done after E1, result=42, err=0, neg=0; done low next cycle.
//  2. RESTA 5,9 -> result=4, neg=1. RESTA 9,5 -> result=4, neg=0.
//  3. MULT 200,200 -> err=1, result=0. MULT 181,181 -> result=32761, err=0.
//  4. SUMA 20000,20000 -> err=1, result=0.
//  5. DIV 100,7 (macro on) -> busy 16 edges, done after E16, result=14, remainder=2.
//     DIV 100,0 -> done after E1, err=1.
//     Macro off: DIV 100,7 -> done after E1, err=1.
//  6. Start DIV 100,7; pulse start with SUMA 1,1 at E5 -> ignored.
//     Assert reset_in at E8 mid-DIV -> outputs 0 immediately, no done.
//     Next SUMA 1,1 -> result=2.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one calculator op per start pulse and returns result/remainder/flags with a done pulse.
// Define ALU_SEQ_DIV_EN to build the iterative restoring divider; without it DIV finishes after one cycle with err=1.

module sumador #(
    parameter int BITS = 15
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] sum,
    output logic            carry
);
    assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

module restador #(
    parameter int BITS = 15
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] diff,
    output logic            neg
);
    assign neg  = (a < b);
    assign diff = neg ? (b - a) : (a - b);
endmodule

module multiplicador #(
    parameter int BITS = 15
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] prod,
    output logic            ovf
);
    logic [2*BITS-1:0] full;

    assign full = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
    assign prod = full[BITS-1:0];
    assign ovf  = |full[2*BITS-1:BITS];
endmodule

module alu_sequencer #(
    parameter int BITS = 15
) (
    input  logic            clk,
    input  logic            reset_in,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [BITS-1:0] lhs,
    input  logic [BITS-1:0] rhs,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] result,
    output logic [BITS-1:0] remainder,
    output logic            neg,
    output logic            err
);
    localparam logic [1:0] OP_SUMA  = 2'd0;
    localparam logic [1:0] OP_RESTA = 2'd1;
    localparam logic [1:0] OP_MULT  = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DIV_RUN,
        S_DIV_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [BITS-1:0] lhs_q, lhs_d;
    logic [BITS-1:0] rhs_q, rhs_d;
    logic [BITS-1:0] result_q, result_d;
    logic [BITS-1:0] remainder_q, remainder_d;
    logic            neg_q, neg_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic [BITS-1:0] sum_val, diff_val, prod_val;
    logic            sum_carry, diff_neg, prod_ovf;

    sumador #(.BITS(BITS)) u_sumador (
        .a     (lhs_q),
        .b     (rhs_q),
        .sum   (sum_val),
        .carry (sum_carry)
    );

    restador #(.BITS(BITS)) u_restador (
        .a    (lhs_q),
        .b    (rhs_q),
        .diff (diff_val),
        .neg  (diff_neg)
    );

    multiplicador #(.BITS(BITS)) u_multiplicador (
        .a    (lhs_q),
        .b    (rhs_q),
        .prod (prod_val),
        .ovf  (prod_ovf)
    );

`ifdef ALU_SEQ_DIV_EN
    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

    // quo_q starts as the dividend and fills with quotient bits from the right as it shifts out.
    logic [BITS-1:0] quo_q, quo_d;
    logic [BITS-1:0] prem_q, prem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS:0]   div_trial;
    logic            div_ge;
    logic [BITS-1:0] div_diff;

    assign div_trial = {prem_q, quo_q[BITS-1]};
    assign div_ge    = (div_trial >= {1'b0, rhs_q});
    // When div_ge holds the true difference is below rhs, so the low BITS bits are exact.
    assign div_diff  = div_trial[BITS-1:0] - rhs_q;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lhs_d       = lhs_q;
        rhs_d       = rhs_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        neg_d       = neg_q;
        err_d       = err_q;
        done_d      = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        quo_d       = quo_q;
        prem_d      = prem_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    lhs_d   = lhs;
                    rhs_d   = rhs;
                    state_d = S_EXEC;
`ifdef ALU_SEQ_DIV_EN
                    if ((op == OP_DIV) && (rhs != '0)) begin
                        state_d = S_DIV_RUN;
                        quo_d   = lhs;
                        prem_d  = '0;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            S_EXEC: begin
                done_d      = 1'b1;
                state_d     = S_IDLE;
                remainder_d = '0;
                neg_d       = 1'b0;
                case (op_q)
                    OP_SUMA: begin
                        err_d    = sum_carry;
                        result_d = sum_carry ? '0 : sum_val;
                    end
                    OP_RESTA: begin
                        err_d    = 1'b0;
                        result_d = diff_val;
                        neg_d    = diff_neg;
                    end
                    OP_MULT: begin
                        err_d    = prod_ovf;
                        result_d = prod_ovf ? '0 : prod_val;
                    end
                    default: begin
                        // DIV only reaches here for a zero divisor or when the divider is not built.
                        err_d    = 1'b1;
                        result_d = '0;
                    end
                endcase
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV_RUN: begin
                prem_d = div_ge ? div_diff : div_trial[BITS-1:0];
                quo_d  = {quo_q[BITS-2:0], div_ge};
                if (cnt_q == CW'(BITS - 1)) begin
                    state_d = S_DIV_FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV_FIN: begin
                done_d      = 1'b1;
                state_d     = S_IDLE;
                result_d    = quo_q;
                remainder_d = prem_q;
                neg_d       = 1'b0;
                err_d       = 1'b0;
                cnt_d       = '0;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            op_q        <= OP_SUMA;
            lhs_q       <= '0;
            rhs_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            quo_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lhs_q       <= lhs_d;
            rhs_q       <= rhs_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            done_q      <= done_d;
`ifdef ALU_SEQ_DIV_EN
            quo_q       <= quo_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign remainder = remainder_q;
    assign neg       = neg_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer (BITS=15): arithmetic vectors, latency, start handshake and mid-op reset.
// DIV expectations follow ALU_SEQ_DIV_EN as seen by this compile.

module tb_alu_sequencer;
    localparam int BITS = 15;

    logic            clk = 1'b0;
    logic            reset_in = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      op = 2'd0;
    logic [BITS-1:0] lhs = '0;
    logic [BITS-1:0] rhs = '0;
    logic            busy, done, neg, err;
    logic [BITS-1:0] result, remainder;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] o;
        int         l;
        int         r;
        int         res;
        int         rem;
        logic       ng;
        logic       er;
        int         cyc;
    } vec_t;

    always #5 clk = ~clk;

    alu_sequencer #(.BITS(BITS)) dut (
        .clk       (clk),
        .reset_in  (reset_in),
        .start     (start),
        .op        (op),
        .lhs       (lhs),
        .rhs       (rhs),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .neg       (neg),
        .err       (err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Drives one start pulse and returns 1 ns after the capturing edge E0.
    task automatic issue_op(input logic [1:0] o, input int l, input int r);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        lhs   = BITS'(l);
        rhs   = BITS'(r);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; limit+1 means it never came.
    task automatic wait_done(input int limit, output int cyc);
        cyc = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({busy, done, result, remainder, neg, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b result=%0d rem=%0d neg=%0b err=%0b expected all 0",
                     busy, done, result, remainder, neg, err);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, result, remainder, neg, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: got busy=%0b done=%0b result=%0d rem=%0d neg=%0b err=%0b expected all 0",
                     busy, done, result, remainder, neg, err);
        end
        $display("reset: busy=%0b done=%0b result=%0d", busy, done, result);
        @(negedge clk);
        reset_in = 1'b0;
    endtask

    task automatic test_suma();
        int cyc;
        issue_op(2'd0, 12, 30);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL suma_busy: got %0b expected 1", busy);
        end
        wait_done(4, cyc);
        n_cmp++;
        if (cyc != 1) begin
            n_bad++;
            $display("FAIL suma_latency: got %0d expected 1", cyc);
        end
        n_cmp++;
        if ({busy, result, remainder, neg, err} !== {1'b0, 15'd42, 15'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL suma_outputs: got busy=%0b result=%0d rem=%0d neg=%0b err=%0b expected 0/42/0/0/0",
                     busy, result, remainder, neg, err);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({done, result} !== {1'b0, 15'd42}) begin
            n_bad++;
            $display("FAIL suma_done_pulse: got done=%0b result=%0d expected done=0 result=42", done, result);
        end
        $display("SUMA 12,30: cyc=%0d result=%0d err=%0b neg=%0b", cyc, result, err, neg);
    endtask

    task automatic test_arith();
        vec_t tbl[8];
        int   cyc;
        tbl[0] = '{2'd1, 5, 9, 4, 0, 1'b1, 1'b0, 1};
        tbl[1] = '{2'd1, 9, 5, 4, 0, 1'b0, 1'b0, 1};
        tbl[2] = '{2'd1, 7, 7, 0, 0, 1'b0, 1'b0, 1};
        tbl[3] = '{2'd2, 200, 200, 0, 0, 1'b0, 1'b1, 1};
        tbl[4] = '{2'd2, 181, 181, 32761, 0, 1'b0, 1'b0, 1};
        tbl[5] = '{2'd2, 32767, 1, 32767, 0, 1'b0, 1'b0, 1};
        tbl[6] = '{2'd0, 20000, 20000, 0, 0, 1'b0, 1'b1, 1};
        tbl[7] = '{2'd0, 16383, 16384, 32767, 0, 1'b0, 1'b0, 1};
        for (int i = 0; i < 8; i++) begin
            issue_op(tbl[i].o, tbl[i].l, tbl[i].r);
            wait_done(4, cyc);
            n_cmp++;
            if (cyc != tbl[i].cyc) begin
                n_bad++;
                $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, cyc, tbl[i].cyc);
            end
            n_cmp++;
            if ({result, remainder, neg, err} !== {BITS'(tbl[i].res), BITS'(tbl[i].rem), tbl[i].ng, tbl[i].er}) begin
                n_bad++;
                $display("FAIL arith_outputs[%0d]: got result=%0d rem=%0d neg=%0b err=%0b expected %0d/%0d/%0b/%0b",
                         i, result, remainder, neg, err, tbl[i].res, tbl[i].rem, tbl[i].ng, tbl[i].er);
            end
            $display("op=%0d %0d,%0d: cyc=%0d result=%0d neg=%0b err=%0b", tbl[i].o, tbl[i].l, tbl[i].r,
                     cyc, result, neg, err);
        end
    endtask

    task automatic test_div();
        vec_t tbl[4];
        int   cyc;
`ifdef ALU_SEQ_DIV_EN
        tbl[0] = '{2'd3, 100, 7, 14, 2, 1'b0, 1'b0, 16};
        tbl[1] = '{2'd3, 100, 0, 0, 0, 1'b0, 1'b1, 1};
        tbl[2] = '{2'd3, 32767, 1, 32767, 0, 1'b0, 1'b0, 16};
        tbl[3] = '{2'd3, 5, 9, 0, 5, 1'b0, 1'b0, 16};
`else
        tbl[0] = '{2'd3, 100, 7, 0, 0, 1'b0, 1'b1, 1};
        tbl[1] = '{2'd3, 100, 0, 0, 0, 1'b0, 1'b1, 1};
        tbl[2] = '{2'd3, 32767, 1, 0, 0, 1'b0, 1'b1, 1};
        tbl[3] = '{2'd3, 5, 9, 0, 0, 1'b0, 1'b1, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            issue_op(tbl[i].o, tbl[i].l, tbl[i].r);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL div_busy[%0d]: got %0b expected 1", i, busy);
            end
            wait_done(24, cyc);
            n_cmp++;
            if (cyc != tbl[i].cyc) begin
                n_bad++;
                $display("FAIL div_latency[%0d]: got %0d expected %0d", i, cyc, tbl[i].cyc);
            end
            n_cmp++;
            if ({busy, result, remainder, neg, err} !== {1'b0, BITS'(tbl[i].res), BITS'(tbl[i].rem), 1'b0, tbl[i].er}) begin
                n_bad++;
                $display("FAIL div_outputs[%0d]: got busy=%0b result=%0d rem=%0d neg=%0b err=%0b expected 0/%0d/%0d/0/%0b",
                         i, busy, result, remainder, neg, err, tbl[i].res, tbl[i].rem, tbl[i].er);
            end
            $display("DIV %0d,%0d: cyc=%0d result=%0d rem=%0d err=%0b", tbl[i].l, tbl[i].r, cyc, result, remainder, err);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1;
        op    = 2'd0;
        lhs   = BITS'(1);
        rhs   = BITS'(2);
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_busy_e0: got %0b expected 1", busy);
        end
        @(negedge clk);
        lhs = BITS'(5);
        rhs = BITS'(5);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({done, result} !== {1'b1, 15'd3}) begin
            n_bad++;
            $display("FAIL b2b_first: got done=%0b result=%0d expected done=1 result=3", done, result);
        end
        $display("SUMA 1,2 (start held): done=%0b result=%0d", done, result);
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_bad++;
            $display("FAIL b2b_accept: got busy=%0b done=%0b expected busy=1 done=0", busy, done);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({done, result, err} !== {1'b1, 15'd10, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_second: got done=%0b result=%0d err=%0b expected done=1 result=10 err=0",
                     done, result, err);
        end
        $display("SUMA 5,5 (accepted in done cycle): done=%0b result=%0d", done, result);
    endtask

    task automatic test_abort();
        logic saw;
        int   cyc;
`ifdef ALU_SEQ_DIV_EN
        issue_op(2'd3, 100, 7);
        saw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 5) begin
                @(negedge clk);
                start = 1'b1;
                op    = 2'd0;
                lhs   = BITS'(1);
                rhs   = BITS'(1);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) saw = 1'b1;
        end
        n_cmp++;
        if ({busy, saw} !== 2'b10) begin
            n_bad++;
            $display("FAIL abort_ignore_start: got busy=%0b saw_done=%0b expected busy=1 saw_done=0", busy, saw);
        end
        $display("DIV 100,7 with SUMA pulse at E5: busy=%0b saw_done=%0b", busy, saw);
`endif
        n_cmp++;
        if (result !== 15'd10) begin
            n_bad++;
            $display("FAIL abort_pre_hold: got result=%0d expected 10", result);
        end
        @(negedge clk);
        reset_in = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, result, remainder, neg, err} !== '0) begin
            n_bad++;
            $display("FAIL abort_reset_clear: got busy=%0b done=%0b result=%0d rem=%0d neg=%0b err=%0b expected all 0",
                     busy, done, result, remainder, neg, err);
        end
        $display("reset asserted: busy=%0b result=%0d", busy, result);
        @(posedge clk);
        @(negedge clk);
        reset_in = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) saw = 1'b1;
        end
        n_cmp++;
        if (saw !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: got activity=%0b expected 0", saw);
        end
        issue_op(2'd0, 1, 1);
        wait_done(4, cyc);
        n_cmp++;
        if ({cyc == 1, result, err} !== {1'b1, 15'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_next_suma: got cyc=%0d result=%0d err=%0b expected cyc=1 result=2 err=0",
                     cyc, result, err);
        end
        $display("SUMA 1,1 after reset: cyc=%0d result=%0d", cyc, result);
    endtask

    initial begin
        test_reset();
        test_suma();
        test_arith();
        test_div();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
